// File: rtl/stream_pkg.sv
// Shared definitions for the stream controller: state encoding, default widths
// and the lowest-index-first start priority function.
package stream_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StWait  = 2'd2,
    StDrain = 2'd3
  } stream_state_e;

  localparam int unsigned DefaultW    = 16;
  localparam int unsigned DefaultCntW = 16;
  localparam int unsigned MaxSrc      = 8;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic int unsigned lowest_idx(input logic [MaxSrc-1:0] req);
    int unsigned idx;
    idx = 0;
    for (int i = MaxSrc - 1; i >= 0; i--) begin
      if (req[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/stream_mux.sv
// Registered N_SRC:1 selector of producer valid/data onto the buffer write port.
// Optional STREAM_CTRL_PARITY_EN adds a registered even-parity bit of wr_data.
module stream_mux
  import stream_pkg::*;
#(
  parameter int unsigned N_SRC = 2,
  parameter int unsigned W     = DefaultW,
  parameter int unsigned CH_W  = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_full,
  input  logic [CH_W-1:0]    i_sel,
  input  logic [N_SRC-1:0]   i_src_valid,
  input  logic [N_SRC*W-1:0] i_src_data,
  output logic               o_sel_valid,
  output logic               o_fwd,
  output logic               o_wr_en,
  output logic [W-1:0]       o_wr_data
`ifdef STREAM_CTRL_PARITY_EN
  ,
  output logic               o_parity
`endif
);

  logic         w_sel_valid;
  logic [W-1:0] w_sel_data;
  logic         w_wr;
  logic         r_wr_en;
  logic [W-1:0] r_wr_data;

  // Select the latched channel's valid and word.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (i_sel == CH_W'(i)) begin
        w_sel_valid = i_src_valid[i];
        w_sel_data  = i_src_data[i*W +: W];
      end
    end
  end

  assign w_wr = i_en & w_sel_valid & ~i_full;

  // Register the write strobe; the data word holds between writes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_wr;
      if (w_wr) r_wr_data <= w_sel_data;
    end
  end

`ifdef STREAM_CTRL_PARITY_EN
  logic r_parity;

  // Parity tracks the word being written on the same edge as wr_data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_parity <= 1'b0;
    end else if (w_wr) begin
      r_parity <= ^w_sel_data;
    end
  end

  assign o_parity = r_parity;
`endif

  assign o_sel_valid = w_sel_valid;
  assign o_fwd       = w_wr;
  assign o_wr_en     = r_wr_en;
  assign o_wr_data   = r_wr_data;

endmodule

// File: rtl/stream_ctrl.sv
// Start/stop arbiter for N_SRC producers feeding one buffer write port.
// One channel owns a session; it is paused on buffer-full and the buffer is
// drained after stop. Optional feature macro: STREAM_CTRL_PARITY_EN.
module stream_ctrl
  import stream_pkg::*;
#(
  parameter int unsigned N_SRC = 2,
  parameter int unsigned W     = DefaultW,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_SRC-1:0]   i_start,
  input  logic               i_stop,
  input  logic               i_buffer_full,
  input  logic               i_buffer_empty,
  input  logic               i_rd_valid,
  input  logic [N_SRC-1:0]   i_src_valid,
  input  logic [N_SRC*W-1:0] i_src_data,
  output logic [N_SRC-1:0]   o_src_en,
  output logic               o_wr_en,
  output logic [W-1:0]       o_wr_data,
  output logic [N_SRC-1:0]   o_active,
  output logic               o_busy,
  output logic [CNT_W-1:0]   o_word_cnt,
  output logic [CNT_W-1:0]   o_drop_cnt
`ifdef STREAM_CTRL_PARITY_EN
  ,
  output logic               o_parity
`endif
);

  localparam int unsigned CH_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  stream_state_e     r_state;
  logic [CH_W-1:0]   r_ch;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic [MaxSrc-1:0] w_start_pad;
  logic [CH_W-1:0]   w_first;
  logic [N_SRC-1:0]  w_onehot;
  logic              w_busy;
  logic              w_sel_valid;
  logic              w_fwd;
  logic              w_drop;

  // Widen start so the shared priority function can serve any N_SRC.
  always_comb begin
    w_start_pad              = '0;
    w_start_pad[N_SRC-1:0]   = i_start;
  end

  assign w_first = CH_W'(lowest_idx(w_start_pad));
  assign w_busy  = (r_state != StIdle);
  assign w_drop  = w_busy & w_sel_valid & i_buffer_full;

  // Session FSM: channel latch on start, pause on full, drain after stop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_ch    <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (|i_start) begin
            r_ch    <= w_first;
            r_state <= StRun;
          end
        end
        StRun: begin
          if (i_stop)             r_state <= StDrain;
          else if (i_buffer_full) r_state <= StWait;
        end
        StWait: begin
          if (i_stop)              r_state <= StDrain;
          else if (!i_buffer_full) r_state <= StRun;
        end
        StDrain: begin
          if (i_buffer_empty && !i_rd_valid) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Per-session counters, cleared when a new session is granted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_word_cnt <= '0;
      r_drop_cnt <= '0;
    end else if ((r_state == StIdle) && (|i_start)) begin
      r_word_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_fwd)  r_word_cnt <= r_word_cnt + 1'b1;
      if (w_drop) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

`ifdef STREAM_CTRL_PARITY_EN
  logic r_run_par;

  // Running parity of the word count, toggled on each increment.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_run_par <= 1'b0;
    end else if (w_fwd) begin
      r_run_par <= ~r_run_par;
    end
  end
`endif

  // Decode the latched channel index to one-hot.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      w_onehot[i] = (r_ch == CH_W'(i));
    end
  end

  stream_mux #(
    .N_SRC (N_SRC),
    .W     (W),
    .CH_W  (CH_W)
  ) u_mux (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (w_busy),
    .i_full      (i_buffer_full),
    .i_sel       (r_ch),
    .i_src_valid (i_src_valid),
    .i_src_data  (i_src_data),
    .o_sel_valid (w_sel_valid),
    .o_fwd       (w_fwd),
    .o_wr_en     (o_wr_en),
    .o_wr_data   (o_wr_data)
`ifdef STREAM_CTRL_PARITY_EN
    ,
    .o_parity    (o_parity)
`endif
  );

  assign o_src_en   = (r_state == StRun) ? w_onehot : '0;
  assign o_active   = w_busy ? w_onehot : '0;
  assign o_busy     = w_busy;
  assign o_word_cnt = r_word_cnt;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_stream_ctrl.sv
// Directed-vector bench for stream_ctrl (N_SRC=2). Covers parity when built
// with STREAM_CTRL_PARITY_EN.
module tb_stream_ctrl;

  localparam int unsigned NV = 19;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  start = '0;
  logic        stop = 1'b0;
  logic        full = 1'b0;
  logic        empty = 1'b1;
  logic        rdv = 1'b0;
  logic [1:0]  valid = '0;
  logic [15:0] d0 = '0;
  logic [15:0] d1 = '0;
  logic [1:0]  src_en;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [1:0]  active;
  logic        busy;
  logic [15:0] word_cnt;
  logic [15:0] drop_cnt;
`ifdef STREAM_CTRL_PARITY_EN
  logic        parity;
`endif

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  stream_ctrl #(
    .N_SRC (2),
    .W     (16),
    .CNT_W (16)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_stop         (stop),
    .i_buffer_full  (full),
    .i_buffer_empty (empty),
    .i_rd_valid     (rdv),
    .i_src_valid    (valid),
    .i_src_data     ({d1, d0}),
    .o_src_en       (src_en),
    .o_wr_en        (wr_en),
    .o_wr_data      (wr_data),
    .o_active       (active),
    .o_busy         (busy),
    .o_word_cnt     (word_cnt),
    .o_drop_cnt     (drop_cnt)
`ifdef STREAM_CTRL_PARITY_EN
    ,
    .o_parity       (parity)
`endif
  );

  typedef struct packed {
    logic        rst;
    logic [1:0]  start;
    logic        stop;
    logic        full;
    logic        empty;
    logic        rdv;
    logic [1:0]  valid;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  e_src_en;
    logic        e_wr_en;
    logic [15:0] e_wr_data;
    logic [1:0]  e_active;
    logic        e_busy;
    logic [15:0] e_wc;
    logic [15:0] e_dc;
    logic        e_cd;   // compare wr_data on this vector
  } vec_t;

  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: inputs already driven, sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    applied++;
  endtask

  initial begin
    //          rst start stop full emp rdv valid d0        d1         src_en wr wr_data   act  bsy wc  dc  cd
    tbl[0]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b0, 16'd0, 16'd0, 1'b1};
    tbl[1]  = '{1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 2'b10, 1'b0, 16'h0000, 2'b10, 1'b1, 16'd0, 16'd0, 1'b0};
    tbl[2]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 16'h0000, 16'h0005, 2'b10, 1'b1, 16'h0005, 2'b10, 1'b1, 16'd1, 16'd0, 1'b1};
    tbl[3]  = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 2'b10, 1'b0, 16'h0000, 2'b10, 1'b1, 16'd1, 16'd0, 1'b0};
    tbl[4]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000, 2'b10, 1'b1, 16'd1, 16'd0, 1'b0};
    tbl[5]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b0, 16'd1, 16'd0, 1'b0};
    tbl[6]  = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'h0000, 2'b01, 1'b1, 16'd0, 16'd0, 1'b0};
    tbl[7]  = '{1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'h0000, 2'b01, 1'b1, 16'd0, 16'd0, 1'b0};
    tbl[8]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 16'h0011, 16'h0000, 2'b01, 1'b1, 16'h0011, 2'b01, 1'b1, 16'd1, 16'd0, 1'b1};
    tbl[9]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 16'h0012, 16'h0000, 2'b00, 1'b0, 16'h0000, 2'b01, 1'b1, 16'd1, 16'd1, 1'b0};
    tbl[10] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 16'h0012, 16'h0000, 2'b00, 1'b0, 16'h0000, 2'b01, 1'b1, 16'd1, 16'd2, 1'b0};
    tbl[11] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 16'h0012, 16'h0000, 2'b00, 1'b0, 16'h0000, 2'b01, 1'b1, 16'd1, 16'd3, 1'b0};
    tbl[12] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 16'h0013, 16'h0000, 2'b01, 1'b1, 16'h0013, 2'b01, 1'b1, 16'd2, 16'd3, 1'b1};
    tbl[13] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 16'h0000, 16'hBEEF, 2'b01, 1'b0, 16'h0000, 2'b01, 1'b1, 16'd2, 16'd3, 1'b0};
    tbl[14] = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000, 2'b01, 1'b1, 16'd2, 16'd3, 1'b0};
    tbl[15] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 16'h0021, 16'h0000, 2'b00, 1'b1, 16'h0021, 2'b01, 1'b1, 16'd3, 16'd3, 1'b1};
    tbl[16] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000, 2'b01, 1'b1, 16'd3, 16'd3, 1'b0};
    tbl[17] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b0, 16'd3, 16'd3, 1'b0};
    tbl[18] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 16'h0031, 16'h0000, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b0, 16'd3, 16'd3, 1'b0};

    for (int i = 0; i < int'(NV); i++) begin
      rst   = tbl[i].rst;
      start = tbl[i].start;
      stop  = tbl[i].stop;
      full  = tbl[i].full;
      empty = tbl[i].empty;
      rdv   = tbl[i].rdv;
      valid = tbl[i].valid;
      d0    = tbl[i].d0;
      d1    = tbl[i].d1;
      tick();
      chk($sformatf("v%0d src_en", i), 32'(src_en), 32'(tbl[i].e_src_en));
      chk($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(tbl[i].e_wr_en));
      if (tbl[i].e_cd) chk($sformatf("v%0d wr_data", i), 32'(wr_data), 32'(tbl[i].e_wr_data));
      chk($sformatf("v%0d active", i), 32'(active), 32'(tbl[i].e_active));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("v%0d word_cnt", i), 32'(word_cnt), 32'(tbl[i].e_wc));
      chk($sformatf("v%0d drop_cnt", i), 32'(drop_cnt), 32'(tbl[i].e_dc));
    end

    // Reset mid-session with word_cnt = 0x0010 and a write in flight.
    rst = 1'b0; stop = 1'b0; full = 1'b0; empty = 1'b1; rdv = 1'b0;
    start = 2'b01; valid = 2'b00;
    tick();
    chk("rs src_en", 32'(src_en), 32'h1);
    start = 2'b00;
    for (int k = 0; k < 16; k++) begin
      valid = 2'b01;
      d0    = 16'(k + 1);
      tick();
    end
    chk("rs word_cnt pre", 32'(word_cnt), 32'h10);
    chk("rs wr_data pre", 32'(wr_data), 32'h10);
    rst = 1'b1; d0 = 16'h0077;
    tick();
    chk("rs src_en", 32'(src_en), 32'h0);
    chk("rs wr_en", 32'(wr_en), 32'h0);
    chk("rs wr_data", 32'(wr_data), 32'h0);
    chk("rs active", 32'(active), 32'h0);
    chk("rs busy", 32'(busy), 32'h0);
    chk("rs word_cnt", 32'(word_cnt), 32'h0);
    chk("rs drop_cnt", 32'(drop_cnt), 32'h0);
    rst = 1'b0; valid = 2'b00;
    tick();
    chk("rs idle busy", 32'(busy), 32'h0);

`ifdef STREAM_CTRL_PARITY_EN
    chk("par reset", 32'(parity), 32'h0);
    start = 2'b01;
    tick();
    start = 2'b00; valid = 2'b01; d0 = 16'h0007;
    tick();
    chk("par 0x7", 32'(parity), 32'h1);
    valid = 2'b00;
    tick();
    chk("par hold", 32'(parity), 32'h1);
    valid = 2'b01; d0 = 16'h0003;
    tick();
    chk("par 0x3", 32'(parity), 32'h0);
    valid = 2'b00;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
